// File: rtl/mem_noc_arb.sv
// mem_noc_arb: packet-atomic round-robin arbiter of N valid/ready sources onto one channel.
// Define MEM_NOC_ARB_REG_OUT_EN for a registered output stage (1-cycle latency).
module mem_noc_arb #(
    parameter  int N   = 2,
    parameter  int W   = 32,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   src_valid,
    output logic [N-1:0]   src_ready,
    input  logic [N-1:0]   src_last,
    input  logic [N*W-1:0] src,
    output logic           dst_valid,
    input  logic           dst_ready,
    output logic [W-1:0]   dst,
    output logic           dst_last,
    output logic [IDW-1:0] dst_id
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_q;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] rr_nxt;
    logic [IDW-1:0] idx;
    logic           have_gnt;
    logic           acc;
    logic           sel_valid;
    logic           sel_last;
    logic [W-1:0]   sel_data;
    logic           hs;
    logic           hs_last;
    logic [W-1:0]   pay [N];

    for (genvar g = 0; g < N; g++) begin : g_pay
        assign pay[g] = src[g*W +: W];
    end

    // Lowest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        grant    = gnt_q;
        have_gnt = (state == LOCK);
        idx      = '0;
        if (state == IDLE) begin
            grant = '0;
            for (int k = N - 1; k >= 0; k--) begin
                idx = IDW'((int'(rr_ptr) + k) % N);
                if (src_valid[idx]) begin
                    grant    = idx;
                    have_gnt = 1'b1;
                end
            end
        end
    end

    assign sel_valid = have_gnt & src_valid[grant];
    assign sel_last  = src_last[grant];
    assign sel_data  = pay[grant];
    assign rr_nxt    = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;

`ifdef MEM_NOC_ARB_REG_OUT_EN
    assign acc = rstn & (~dst_valid | dst_ready);
`else
    assign acc = rstn & dst_ready;
`endif

    assign hs      = sel_valid & acc;
    assign hs_last = hs & sel_last;

    always_comb begin
        src_ready = '0;
        if (have_gnt) begin
            src_ready[grant] = acc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_q  <= '0;
        end else if (hs_last) begin
            state  <= IDLE;
            rr_ptr <= rr_nxt;
        end else if (state == IDLE && have_gnt) begin
            state <= LOCK;
            gnt_q <= grant;
        end
    end

`ifdef MEM_NOC_ARB_REG_OUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dst_valid <= 1'b0;
            dst       <= '0;
            dst_last  <= 1'b0;
            dst_id    <= '0;
        end else begin
            if (acc) begin
                dst_valid <= sel_valid;
            end
            if (hs) begin
                dst      <= sel_data;
                dst_last <= sel_last;
                dst_id   <= grant;
            end
        end
    end
`else
    // Outputs are forced low while reset is held, matching the registered build.
    assign dst_valid = rstn & sel_valid;
    assign dst       = (rstn && have_gnt) ? sel_data : '0;
    assign dst_last  = rstn & have_gnt & sel_last;
    assign dst_id    = (rstn && have_gnt) ? grant : '0;
`endif

endmodule

// File: tb/tb_mem_noc_arb.sv
// tb_mem_noc_arb: directed vectors and corner sequences for mem_noc_arb
// (N=4 and N=3 instances), valid for both output-stage builds.
module tb_mem_noc_arb;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]     v4, r4, l4;
    logic [4*W-1:0] s4;
    logic           dv4, dr4, dl4;
    logic [W-1:0]   d4;
    logic [1:0]     id4;

    logic [2:0]     v3, r3, l3;
    logic [3*W-1:0] s3;
    logic           dv3, dr3, dl3;
    logic [W-1:0]   d3;
    logic [1:0]     id3;

    mem_noc_arb #(.N(4), .W(W)) u4 (
        .clk(clk), .rstn(rstn),
        .src_valid(v4), .src_ready(r4), .src_last(l4), .src(s4),
        .dst_valid(dv4), .dst_ready(dr4), .dst(d4),
        .dst_last(dl4), .dst_id(id4)
    );

    mem_noc_arb #(.N(3), .W(W)) u3 (
        .clk(clk), .rstn(rstn),
        .src_valid(v3), .src_ready(r3), .src_last(l3), .src(s3),
        .dst_valid(dv3), .dst_ready(dr3), .dst(d3),
        .dst_last(dl3), .dst_id(id3)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
        logic [1:0]   id;
    } beat_t;

    beat_t got[$];
    beat_t expq[$];

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic [3:0] er;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_beats(input string name);
        int n;
        chk({name, "_count"}, 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_%0d", name, i), 32'(got[i]), 32'(expq[i]));
        end
        got.delete();
        expq.delete();
    endtask

    // Beats are recorded once inputs are settled, ahead of the edge that takes them.
    always @(negedge clk) begin
        #2;
        if (rstn && dv4 && dr4) begin
            got.push_back(beat_t'{d: d4, last: dl4, id: id4});
        end
    end

    initial begin
        int idx;
        int t;
        bit zero_done;
        logic [W-1:0] stall_d;

        tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[5]  = '{4'b0011, 4'b0001, 4'b0010};
        tbl[6]  = '{4'b0011, 4'b0001, 4'b0010};
        tbl[7]  = '{4'b0011, 4'b0011, 4'b0010};
        tbl[8]  = '{4'b0011, 4'b0011, 4'b0001};
        tbl[9]  = '{4'b0101, 4'b0000, 4'b0100};
        tbl[10] = '{4'b0001, 4'b0001, 4'b0100};
        tbl[11] = '{4'b0101, 4'b0101, 4'b0100};
        tbl[12] = '{4'b0001, 4'b0001, 4'b0001};

        v4 = 4'b1111; l4 = 4'b1111; s4 = '0; dr4 = 1'b1;
        v3 = 3'b111;  l3 = 3'b111;  s3 = '0; dr3 = 1'b1;

        // Reset held with every source requesting.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready4", 32'(r4), 32'(0));
        chk("rst_valid4", 32'(dv4), 32'(0));
        chk("rst_id4", 32'(id4), 32'(0));
        chk("rst_dst4", 32'(d4), 32'(0));
        chk("rst_ready3", 32'(r3), 32'(0));
        chk("rst_valid3", 32'(dv3), 32'(0));

        @(negedge clk);
        rstn = 1'b1;
        v4 = '0;
        v3 = '0;

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            v4 = tbl[k].v;
            l4 = tbl[k].l;
            for (int i = 0; i < 4; i++) s4[i*W +: W] = W'(k * 4 + i);
            #1;
            chk($sformatf("tbl_ready_%0d", k), 32'(r4), 32'(tbl[k].er));
            for (int i = 0; i < 4; i++) begin
                if (tbl[k].er[i] && tbl[k].v[i]) begin
                    expq.push_back(beat_t'{d: W'(k * 4 + i), last: tbl[k].l[i],
                                           id: 2'(i)});
                end
            end
        end
        @(negedge clk);
        v4 = '0;
        repeat (2) @(negedge clk);
        cmp_beats("tbl_beat");

        // Backpressure mid-packet: req3 sends 3 beats, req0 waits behind it.
`ifdef MEM_NOC_ARB_REG_OUT_EN
        stall_d = W'(8'h30);
`else
        stall_d = W'(8'h31);
`endif
        idx = 0;
        zero_done = 1'b0;
        t = 0;
        while (t < 30 && (idx < 3 || !zero_done)) begin
            @(negedge clk);
            dr4 = !(t >= 1 && t <= 5);
            v4 = {idx < 3, 2'b00, !zero_done};
            l4 = {idx == 2, 2'b00, 1'b1};
            s4 = '0;
            s4[3*W +: W] = W'(8'h30 + idx);
            s4[0 +: W] = W'(8'h0A);
            #1;
            if (t >= 1 && t <= 5) begin
                chk($sformatf("bp_valid_%0d", t), 32'(dv4), 32'(1));
                chk($sformatf("bp_id_%0d", t), 32'(id4), 32'(3));
                chk($sformatf("bp_dst_%0d", t), 32'(d4), 32'(stall_d));
                chk($sformatf("bp_ready_%0d", t), 32'(r4), 32'(0));
            end
            if (v4[3] && r4[3]) idx++;
            if (v4[0] && r4[0]) zero_done = 1'b1;
            t++;
        end
        chk("bp_done", 32'(idx == 3 && zero_done), 32'(1));
        expq.push_back(beat_t'{d: W'(8'h30), last: 1'b0, id: 2'd3});
        expq.push_back(beat_t'{d: W'(8'h31), last: 1'b0, id: 2'd3});
        expq.push_back(beat_t'{d: W'(8'h32), last: 1'b1, id: 2'd3});
        expq.push_back(beat_t'{d: W'(8'h0A), last: 1'b1, id: 2'd0});
        @(negedge clk);
        v4 = '0;
        dr4 = 1'b1;
        repeat (2) @(negedge clk);
        cmp_beats("bp_beat");

        // N=3 pointer wrap, then reset in the middle of a packet.
        @(negedge clk);
        v3 = 3'b010; l3 = 3'b111;
        #1 chk("wrap_r1", 32'(r3), 32'(3'b010));
        @(negedge clk);
        v3 = 3'b101;
        #1 chk("wrap_r2", 32'(r3), 32'(3'b100));
        @(negedge clk);
        #1 chk("wrap_r0", 32'(r3), 32'(3'b001));
        @(negedge clk);
        v3 = 3'b010; l3 = 3'b000;
        #1 chk("mid_first", 32'(r3), 32'(3'b010));
        @(negedge clk);
        v3 = 3'b111; l3 = 3'b111;
        #1 chk("mid_locked", 32'(r3), 32'(3'b010));

        @(negedge clk);
        rstn = 1'b0;
        v4 = 4'b1111; l4 = 4'b1111;
        #1;
        chk("mrst_ready3", 32'(r3), 32'(0));
        chk("mrst_valid3", 32'(dv3), 32'(0));
        chk("mrst_id3", 32'(id3), 32'(0));
        chk("mrst_dst3", 32'(d3), 32'(0));
        chk("mrst_ready4", 32'(r4), 32'(0));
        chk("mrst_valid4", 32'(dv4), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("after_rst3", 32'(r3), 32'(3'b001));
        chk("after_rst4", 32'(r4), 32'(4'b0001));
        @(negedge clk);
        v3 = '0;
        v4 = '0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_noc_arb.md
MEM_NOC_ARB -- requirements
Module: mem_noc_arb

Interface
REQ-001 SHALL have parameter N, default 2: number of requesters, legal 1..8.
REQ-002 SHALL have parameter W, default 32: payload width per requester.
REQ-003 SHALL have local parameter IDW = max(1, clog2(N)).
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port src_valid  input  N: per-requester beat valid.
REQ-007 SHALL have port src_ready  output  N: per-requester beat accept.
REQ-008 SHALL have port src_last  input  N: beat is the final beat of its packet.
REQ-009 SHALL have port src  input  N*W: payloads, requester i at bits [i*W +: W].
REQ-010 SHALL have port dst_valid  output  1: shared channel valid.
REQ-011 SHALL have port dst_ready  input  1: shared channel accept.
REQ-012 SHALL have port dst  output  W: granted payload.
REQ-013 SHALL have port dst_last  output  1: granted last flag.
REQ-014 SHALL have port dst_id  output  IDW: index of the requester that sourced the beat.

Function
REQ-015 SHALL arbitrate N requesters onto one valid/ready channel, packet-atomic, round-robin.
REQ-016 SHALL keep state IDLE or LOCK, plus a rr_ptr (IDW bits) and a locked grant register gnt_q.
- IDLE: grant = first i with src_valid[i], searching rr_ptr, rr_ptr+1, ..., wrapping N-1 -> 0.
- LOCK: grant = gnt_q; other requesters are ignored.
REQ-017 SHALL drive src_ready[grant] = internal accept (acc); every other src_ready bit SHALL be 0; with no grant, all bits SHALL be 0.
REQ-018 SHALL apply the following IDLE transitions:
- granted beat handshaked with src_last=1 -> stay IDLE;
- handshaked with src_last=0 -> LOCK;
- valid but not accepted -> LOCK.
- In the LOCK cases gnt_q <= grant.
REQ-019 SHALL leave LOCK -> IDLE only on handshake of the granted requester with src_last=1.
REQ-020 SHALL update rr_ptr to (grant+1) mod N on every last-beat handshake, and at no other time.
REQ-021 SHALL hold the grant while the granted src_valid is low in LOCK: no timeout and no re-arbitration.
REQ-022 SHALL treat N=1 as grant always 0, with rr_ptr held at 0.

Reset
REQ-023 SHALL apply the following while rstn=0, asynchronously:
- state=IDLE, rr_ptr=0, gnt_q=0;
- dst_valid=0, dst=0, dst_last=0, dst_id=0.
REQ-024 SHALL discard any partial packet on reset mid-packet; after release, arbitration restarts from requester 0.

Configuration
REQ-025 SHALL use macro MEM_NOC_ARB_REG_OUT_EN to select the output stage.
REQ-026 SHALL behave as follows with MEM_NOC_ARB_REG_OUT_EN defined:
- outputs are registered, latency 1 cycle;
- acc = ~dst_valid | dst_ready;
- when acc, dst_valid <= granted src_valid;
- {dst, dst_last, dst_id} load only on a source handshake.
- Full throughput, one beat per cycle.
REQ-027 SHALL behave as follows with MEM_NOC_ARB_REG_OUT_EN undefined:
- combinational path, latency 0;
- acc = dst_ready;
- dst_valid = granted src_valid; dst, dst_last and dst_id taken directly from the granted requester;
- dst_valid = 0 when there is no grant.
REQ-028 SHALL keep dst, dst_last and dst_id stable while dst_valid=1 and dst_ready=0, in both configurations.

Verification
REQ-029 SHALL cover reset: rstn low with all src_valid=1 -> dst_valid=0, all src_ready=0; after release, first grant to requester 0.
REQ-030 SHALL cover round-robin: N=4, all four requesters sending 1-beat packets with dst_ready=1 -> dst_id sequence 0,1,2,3,0; REG_OUT adds 1 cycle offset.
REQ-031 SHALL cover packet lock: req1 sends a 3-beat packet (last on beat 3) while req0 is also valid -> dst_id=1 for 3 consecutive beats, then 0.
REQ-032 SHALL cover backpressure: dst_ready=0 for 5 cycles mid-packet -> dst and dst_id stable, no grant change, no beat lost or duplicated.
REQ-033 SHALL cover a valid gap: granted requester drops src_valid after beat 1 of 2 -> other requesters stay blocked until its last beat is accepted.
REQ-034 SHALL cover pointer wrap: N=3, rr_ptr=2, requesters 0 and 2 valid -> grant 2, then 0; and reset asserted mid-packet -> state IDLE, rr_ptr=0.
